// File: rtl/pump_cmd_panel.sv
// rtl/pump_cmd_panel.sv - debounced front-panel buttons to pump command pulses and selections
module pump_cmd_panel #(
  parameter int DEBOUNCE_CYCLES = 20_000,
  parameter int CNT_W           = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_frag,
  input  logic       btn_timer,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_manual,
  output logic [1:0] fragrance_select,
  output logic [1:0] timer_select,
  output logic       pump_on,
  output logic       pump_off,
  output logic       manual_on,
  output logic       running,
  output logic [1:0] run_fragrance
);

  localparam int NB       = 5;
  localparam int B_FRAG   = 0;
  localparam int B_TIMER  = 1;
  localparam int B_START  = 2;
  localparam int B_STOP   = 3;
  localparam int B_MANUAL = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    sync_a;
  logic [NB-1:0]    sync_b;
  logic [NB-1:0]    deb;
  logic [NB-1:0]    deb_prev;
  logic [NB-1:0]    press;
  logic [CNT_W-1:0] cnt [NB];

  logic [1:0] frag_next;
  logic [1:0] timer_next;
  logic       on_next;
  logic       off_next;
  logic       man_next;
  logic       running_next;
  logic [1:0] run_frag_next;

  assign btn_raw = {btn_manual, btn_stop, btn_start, btn_timer, btn_frag};

  function automatic logic [1:0] step3(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Counter only advances while the level disagrees; any agreement restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync_b[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_prev <= '0;
      press    <= '0;
    end else begin
      deb_prev <= deb;
      press    <= deb & ~deb_prev;
    end
  end

  // Commands read the registered selection, so a same-cycle step is not yet visible.
  always_comb begin
    frag_next     = fragrance_select;
    timer_next    = timer_select;
    on_next       = 1'b0;
    off_next      = 1'b0;
    man_next      = 1'b0;
    running_next  = running;
    run_frag_next = run_fragrance;
    if (press[B_FRAG])  frag_next  = step3(fragrance_select);
    if (press[B_TIMER]) timer_next = step3(timer_select);
    if (press[B_STOP]) begin
      off_next     = 1'b1;
      running_next = 1'b0;
    end else if (press[B_START]) begin
      on_next       = 1'b1;
      running_next  = 1'b1;
      run_frag_next = fragrance_select;
    end else if (press[B_MANUAL] && !running) begin
      man_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fragrance_select <= '0;
      timer_select     <= '0;
      pump_on          <= 1'b0;
      pump_off         <= 1'b0;
      manual_on        <= 1'b0;
      running          <= 1'b0;
      run_fragrance    <= '0;
    end else begin
      fragrance_select <= frag_next;
      timer_select     <= timer_next;
      pump_on          <= on_next;
      pump_off         <= off_next;
      manual_on        <= man_next;
      running          <= running_next;
      run_fragrance    <= run_frag_next;
    end
  end

endmodule

// File: doc/pump_cmd_panel.md
# pump_cmd_panel

Front-panel command stage feeding the pump controller. It takes five raw push-buttons and synchronizes and debounces each one. It turns the button presses into the single-cycle `pump_on` / `pump_off` / `manual_on` command pulses and the stable `fragrance_select` / `timer_select` codes that the pump controller consumes. It also tracks run status (`running`, `run_fragrance`) for the LCD status path.

## Interface
- `DEBOUNCE_CYCLES`, default 20_000: consecutive stable cycles required to accept a level change (20 ms at 1 MHz); legal range ≥ 2.
- `CNT_W`, default 15: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.

Ports:
- `clk`  in  1  system clock (1 MHz).
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `btn_frag`  in  1  raw button, active-high, asynchronous: step the fragrance selection.
- `btn_timer`  in  1  raw button: step the timer selection.
- `btn_start`  in  1  raw button: start the periodic pump.
- `btn_stop`  in  1  raw button: stop all pumps.
- `btn_manual`  in  1  raw button: one-shot manual pulse.
- `fragrance_select`  out  2  current fragrance: 0, 1 or 2.
- `timer_select`  out  2  current period code: 0, 1 or 2.
- `pump_on`  out  1  one-cycle start command.
- `pump_off`  out  1  one-cycle stop command.
- `manual_on`  out  1  one-cycle manual command.
- `running`  out  1  periodic pump active.
- `run_fragrance`  out  2  fragrance latched at the last accepted start.

## Operation
- Per button, three stages in series:
  - 2-FF synchronizer.
  - Debouncer: counter increments while the synchronized value differs from the debounced value, and clears to 0 whenever they are equal. When the counter is at `DEBOUNCE_CYCLES-1` and the values still differ, the debounced value takes the synchronized value and the counter clears.
  - Rising-edge detector on the debounced value gives a one-cycle press event. Release events are ignored.
- `frag` press: `fragrance_select` steps 0→1→2→0. Code 3 is never produced.
- `timer` press: `timer_select` steps 0→1→2→0 the same way.
- Command arbitration when several command events occur in the same cycle: stop > start > manual. Only the winner is issued.
- Stop event: `pump_off`=1 for one cycle; `running`←0. A stop is issued even if `running`=0.
- Start event: `pump_on`=1 for one cycle; `running`←1; `run_fragrance`←`fragrance_select` value of that same cycle. If `running`=1, the start is still issued; the downstream controller uses it to switch fragrance.
- Manual event: `manual_on`=1 for one cycle, only when `running`=0. A manual event while running is dropped with no pulse.
- Selection events and command events in the same cycle:
  - Both are processed.
  - The command sees the pre-update `fragrance_select`, i.e. the register value, not the stepped value.
  - The pulse and the new select value appear on the same output cycle.
- At most one of `pump_on` / `pump_off` / `manual_on` is high in any cycle.

## Timing
- Reset values (all outputs and all internal state 0):
  - `fragrance_select`=0, `timer_select`=0, `running`=0, `run_fragrance`=0.
  - `pump_on`=`pump_off`=`manual_on`=0.
  - Synchronizers, debounced levels and counters = 0.
- Reset asserted mid-debounce or mid-pulse: all outputs clear immediately, with no pulse emitted afterwards for that press.
- Button held high across reset release: it produces a press event one full debounce window after release (debounced state starts at 0).
- Latency: raw input first sampled high at edge N gives its output pulse / select update registered at edge N+`DEBOUNCE_CYCLES`+3, held for exactly one cycle.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no event and leaves the counter at 0.
- Holding a button produces exactly one event: no auto-repeat.
- Press-to-press minimum spacing is `2*DEBOUNCE_CYCLES` (press plus release windows).
- All outputs are registered. No combinational path from any `btn_*` input to any output.

## Test plan
Run with `DEBOUNCE_CYCLES`=4.
1. Reset, then one clean `btn_frag` press held for 10 cycles → `fragrance_select` 0→1 exactly 7 edges after the first sampled high. Three more presses → 2, 0, 1.
2. `btn_start` bounce pattern 1,0,1,1,0,1,1,1,1,1 → exactly one `pump_on` pulse of 1 cycle, timed from the final stable run. `running`=1. `run_fragrance`=current select.
3. With `running`=1, press `btn_manual` → no `manual_on`. Press `btn_stop` → `pump_off` 1 cycle, `running`=0. Press `btn_manual` again → `manual_on` 1 cycle.
4. `btn_start` and `btn_stop` pressed on the same cycle → only `pump_off`, `running`=0. Then `btn_start` + `btn_manual` together → only `pump_on`.
5. `btn_frag` + `btn_start` together with select=2 → `pump_on` with `run_fragrance`=2, and `fragrance_select`=0 on the same output cycle.
6. Assert `rst` for 1 cycle, 2 cycles into a `btn_timer` debounce while `timer_select`=1 → all outputs 0 immediately. The still-held button yields `timer_select`=1 one window after release.
